// File: rtl/rx_serial_8n1.sv
// Serial receiver, 16x oversampled, mid-bit capture; 8N1 by default.
// Define RX_SERIAL_PARIDADE_EN for 8E1 frames with even-parity checking.
`timescale 1ns/1ps
module rx_serial_8n1 #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       recebe,
    output logic [7:0] dado_recebido,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_frame,
    output logic       erro_paridade,
    output logic [3:0] db_estado
);

    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
`ifdef RX_SERIAL_PARIDADE_EN
    localparam logic [3:0] LAST_BIT = 4'd9;
`else
    localparam logic [3:0] LAST_BIT = 4'd8;
`endif

    typedef enum logic [3:0] {
        Inicial  = 4'h0,
        Confirma = 4'h1,
        Espera   = 4'h3,
        Recepcao = 4'h7,
        FinalRx  = 4'hF
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    sync_q;
    logic          rx;
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [3:0]    tcnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          stop_q;
    logic [7:0]    dado_q;
    logic          tem_dado_q;
    logic          erro_frame_q;
    logic          inicia;

    assign rx   = sync_q[1];
    assign tick = (tick_cnt_q == TICK_LAST);

    // tcnt_q counts ticks mod 16 from the start edge: the start sample lands at
    // tcnt 8 and every later sample again at tcnt 8, one cycle after its tick.
    always_comb begin
        estado_d  = estado_q;
        db_estado = estado_q;
        pronto    = 1'b0;
        case (estado_q)
            Inicial:  if (!rx) estado_d = Confirma;
            Confirma: if (tcnt_q == 4'd8) estado_d = rx ? Inicial : Espera;
            Espera:   if (tick && tcnt_q == 4'd7) estado_d = Recepcao;
            Recepcao: estado_d = (bit_cnt_q == LAST_BIT) ? FinalRx : Espera;
            FinalRx: begin
                estado_d = Inicial;
                pronto   = 1'b1;
            end
            default: begin
                estado_d  = Inicial;
                db_estado = 4'hE;
            end
        endcase
    end

    assign inicia = (estado_q == Inicial) && (estado_d == Confirma);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= Inicial;
            sync_q   <= 2'b11;
        end else begin
            estado_q <= estado_d;
            sync_q   <= {sync_q[0], dado_serial};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tcnt_q     <= '0;
        end else if (inicia) begin
            tick_cnt_q <= '0;
            tcnt_q     <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) tcnt_q <= tcnt_q + 1'b1;
        end
    end

`ifdef RX_SERIAL_PARIDADE_EN
    logic par_q;
    logic erro_paridade_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q           <= 1'b0;
            erro_paridade_q <= 1'b0;
        end else begin
            if (estado_q == Recepcao && bit_cnt_q == 4'd8) par_q <= rx;
            if (estado_q == FinalRx) erro_paridade_q <= (^shift_q) ^ par_q;
        end
    end

    assign erro_paridade = erro_paridade_q;
`else
    assign erro_paridade = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            stop_q       <= 1'b0;
            dado_q       <= '0;
            tem_dado_q   <= 1'b0;
            erro_frame_q <= 1'b0;
        end else begin
            if (estado_q == Confirma && tcnt_q == 4'd8 && !rx) bit_cnt_q <= '0;
            if (estado_q == Recepcao) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) stop_q <= rx;
                else if (bit_cnt_q < 4'd8) shift_q <= {rx, shift_q[7:1]};
            end
            // Set beats acknowledge when both land in the same cycle.
            if (estado_q == FinalRx) begin
                dado_q       <= shift_q;
                erro_frame_q <= !stop_q;
                tem_dado_q   <= 1'b1;
            end else if (recebe) begin
                tem_dado_q <= 1'b0;
            end
        end
    end

    assign dado_recebido = dado_q;
    assign tem_dado      = tem_dado_q;
    assign erro_frame    = erro_frame_q;

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Directed self-checking bench for rx_serial_8n1 at DIV=1 (16 cycles per bit).
`timescale 1ns/1ps
module tb_rx_serial_8n1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic       recebe = 1'b0;
    logic [7:0] dado_recebido;
    logic       pronto;
    logic       tem_dado;
    logic       erro_frame;
    logic       erro_paridade;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pronto_cnt = 0;
    int pronto_cyc = 0;
    int fall_cyc = 0;

`ifdef RX_SERIAL_PARIDADE_EN
    localparam int LAT_NOM = 170;
    localparam int LAT_ACK = 172;
    logic par_flip = 1'b0;
`else
    localparam int LAT_NOM = 154;
    localparam int LAT_ACK = 156;
`endif

    rx_serial_8n1 #(
        .CLK_HZ(1_600_000),
        .BAUD  (100_000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dado_serial  (dado_serial),
        .recebe       (recebe),
        .dado_recebido(dado_recebido),
        .pronto       (pronto),
        .tem_dado     (tem_dado),
        .erro_frame   (erro_frame),
        .erro_paridade(erro_paridade),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto) begin
            pronto_cnt <= pronto_cnt + 1;
            pronto_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        fall_cyc = cyc;
        dado_serial = 1'b0;
        tick_n(16);
        for (int i = 0; i < 8; i++) begin
            dado_serial = d[i];
            tick_n(16);
        end
`ifdef RX_SERIAL_PARIDADE_EN
        dado_serial = (^d) ^ par_flip;
        tick_n(16);
`endif
        dado_serial = stop;
        tick_n(16);
        dado_serial = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick_n(3);
        tests++; if (dado_recebido !== 8'h00) begin fails++; $display("FAIL reset_dado: got %h want 00", dado_recebido); end
        tests++; if (pronto !== 1'b0) begin fails++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        tests++; if (tem_dado !== 1'b0) begin fails++; $display("FAIL reset_tem_dado: got %b want 0", tem_dado); end
        tests++; if (erro_frame !== 1'b0) begin fails++; $display("FAIL reset_erro_frame: got %b want 0", erro_frame); end
        tests++; if (erro_paridade !== 1'b0) begin fails++; $display("FAIL reset_erro_paridade: got %b want 0", erro_paridade); end
        tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL reset_db_estado: got %h want 0", db_estado); end
        reset = 1'b0;
        tick_n(4);
    endtask

    task automatic test_single_frame;
        int p0;
        int lat;
        p0 = pronto_cnt;
        send_frame(8'h55, 1'b1);
        lat = pronto_cyc - fall_cyc;
        tests++; if (pronto_cnt - p0 !== 1) begin fails++; $display("FAIL single_pronto_count: got %0d want 1", pronto_cnt - p0); end
        tests++; if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin fails++; $display("FAIL single_latency: got %0d want %0d+/-2", lat, LAT_NOM); end
        tests++; if (dado_recebido !== 8'h55) begin fails++; $display("FAIL single_dado: got %h want 55", dado_recebido); end
        tests++; if (tem_dado !== 1'b1) begin fails++; $display("FAIL single_tem_dado: got %b want 1", tem_dado); end
        tests++; if (erro_frame !== 1'b0) begin fails++; $display("FAIL single_erro_frame: got %b want 0", erro_frame); end
        tick_n(32);
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        tick_n(4);
        dado_serial = 1'b1;
        tick_n(2);
        tests++; if (db_estado !== 4'h1) begin fails++; $display("FAIL glitch_confirma: got %h want 1", db_estado); end
        tick_n(14);
        tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL glitch_inicial: got %h want 0", db_estado); end
        tests++; if (pronto_cnt - p0 !== 0) begin fails++; $display("FAIL glitch_no_pronto: got %0d want 0", pronto_cnt - p0); end
        tick_n(16);
    endtask

    task automatic test_frame_error;
        int p0;
        p0 = pronto_cnt;
        send_frame(8'hA3, 1'b0);
        tick_n(40);
        tests++; if (pronto_cnt - p0 !== 1) begin fails++; $display("FAIL ferr_pronto_count: got %0d want 1", pronto_cnt - p0); end
        tests++; if (dado_recebido !== 8'hA3) begin fails++; $display("FAIL ferr_dado: got %h want a3", dado_recebido); end
        tests++; if (erro_frame !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %b want 1", erro_frame); end
        send_frame(8'h0F, 1'b1);
        tick_n(32);
        tests++; if (dado_recebido !== 8'h0F) begin fails++; $display("FAIL ferr_next_dado: got %h want 0f", dado_recebido); end
        tests++; if (erro_frame !== 1'b0) begin fails++; $display("FAIL ferr_cleared: got %b want 0", erro_frame); end
    endtask

    task automatic test_recebe;
        recebe = 1'b1;
        tick_n(1);
        recebe = 1'b0;
        tests++; if (tem_dado !== 1'b0) begin fails++; $display("FAIL recebe_clear: got %b want 0", tem_dado); end
        recebe = 1'b1;
        tick_n(1);
        recebe = 1'b0;
        tests++; if (tem_dado !== 1'b0) begin fails++; $display("FAIL recebe_idle_tem_dado: got %b want 0", tem_dado); end
        tests++; if (dado_recebido !== 8'h0F) begin fails++; $display("FAIL recebe_idle_dado: got %h want 0f", dado_recebido); end
        tick_n(4);
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pronto_cnt;
        send_frame(8'h12, 1'b1);
        tests++; if (dado_recebido !== 8'h12) begin fails++; $display("FAIL b2b_first_dado: got %h want 12", dado_recebido); end
        tests++; if (tem_dado !== 1'b1) begin fails++; $display("FAIL b2b_first_tem_dado: got %b want 1", tem_dado); end
        send_frame(8'h34, 1'b1);
        tests++; if (pronto_cnt - p0 !== 2) begin fails++; $display("FAIL b2b_pronto_count: got %0d want 2", pronto_cnt - p0); end
        tests++; if (dado_recebido !== 8'h34) begin fails++; $display("FAIL b2b_dado: got %h want 34", dado_recebido); end
        tests++; if (tem_dado !== 1'b1) begin fails++; $display("FAIL b2b_tem_dado: got %b want 1", tem_dado); end
        tick_n(32);
    endtask

    task automatic test_recebe_collision;
        fork
            send_frame(8'h56, 1'b1);
            begin
                tick_n(LAT_ACK);
                recebe = 1'b1;
                tick_n(1);
                recebe = 1'b0;
            end
        join
        tests++; if (tem_dado !== 1'b1) begin fails++; $display("FAIL collision_tem_dado: got %b want 1", tem_dado); end
        tests++; if (dado_recebido !== 8'h56) begin fails++; $display("FAIL collision_dado: got %h want 56", dado_recebido); end
        tick_n(32);
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        p0 = pronto_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick_n(88);
                reset = 1'b1;
                #2;
                tests++; if (dado_recebido !== 8'h00) begin fails++; $display("FAIL midrst_dado: got %h want 00", dado_recebido); end
                tests++; if (tem_dado !== 1'b0) begin fails++; $display("FAIL midrst_tem_dado: got %b want 0", tem_dado); end
                tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL midrst_db_estado: got %h want 0", db_estado); end
                tests++; if (pronto !== 1'b0 || erro_frame !== 1'b0 || erro_paridade !== 1'b0) begin
                    fails++;
                    $display("FAIL midrst_flags: got pronto=%b ef=%b ep=%b want 0 0 0", pronto, erro_frame, erro_paridade);
                end
                tick_n(2);
                reset = 1'b0;
            end
        join
        tick_n(32);
        tests++; if (pronto_cnt - p0 !== 0) begin fails++; $display("FAIL midrst_no_pronto: got %0d want 0", pronto_cnt - p0); end
        send_frame(8'h81, 1'b1);
        tick_n(8);
        tests++; if (dado_recebido !== 8'h81) begin fails++; $display("FAIL midrst_next_dado: got %h want 81", dado_recebido); end
        tests++; if (tem_dado !== 1'b1 || erro_frame !== 1'b0) begin
            fails++;
            $display("FAIL midrst_next_flags: got td=%b ef=%b want 1 0", tem_dado, erro_frame);
        end
        tick_n(32);
    endtask

    task automatic test_parity;
`ifdef RX_SERIAL_PARIDADE_EN
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1);
        tick_n(8);
        tests++; if (erro_paridade !== 1'b0) begin fails++; $display("FAIL parity_good: got %b want 0", erro_paridade); end
        tests++; if (dado_recebido !== 8'h03) begin fails++; $display("FAIL parity_good_dado: got %h want 03", dado_recebido); end
        tick_n(32);
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        par_flip = 1'b0;
        tick_n(8);
        tests++; if (erro_paridade !== 1'b1) begin fails++; $display("FAIL parity_bad: got %b want 1", erro_paridade); end
        tests++; if (dado_recebido !== 8'h03) begin fails++; $display("FAIL parity_bad_dado: got %h want 03", dado_recebido); end
`else
        send_frame(8'h07, 1'b1);
        tick_n(8);
        tests++; if (erro_paridade !== 1'b0) begin fails++; $display("FAIL parity_off: got %b want 0", erro_paridade); end
        tests++; if (dado_recebido !== 8'h07) begin fails++; $display("FAIL parity_off_dado: got %h want 07", dado_recebido); end
`endif
        tick_n(32);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_recebe();
        test_back_to_back();
        test_recebe_collision();
        test_reset_mid_frame();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_serial_8n1.md
# rx_serial_8n1

Asynchronous serial receiver: the receive-side counterpart of the team's `tx_serial` transmitter, sitting between the UART pin and the parallel consumer logic.
- Frame: LSB-first, 1 start bit, 8 data bits, 1 stop bit; optional even parity (see Configuration).
- Samples with 16x oversampling and captures each bit at its midpoint.
- Presents each received byte with a one-cycle `pronto` pulse and a sticky `tem_dado` flag the consumer clears.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate. Tick divisor `DIV = CLK_HZ/(BAUD*16)`, integer floor, minimum 1.
- `clock` in 1: system clock, rising edge. Reset is `reset`, asynchronous, active-high; clock is `clock`.
- `reset` in 1: asynchronous, active-high.
- `dado_serial` in 1: serial line, idle high, asynchronous to `clock`.
- `recebe` in 1: consumer acknowledge; clears `tem_dado`.
- `dado_recebido` out 8: last received byte.
- `pronto` out 1: one-cycle pulse when a frame completes.
- `tem_dado` out 1: unread byte available.
- `erro_frame` out 1: stop bit of the last frame sampled as 0.
- `erro_paridade` out 1: parity mismatch on the last frame; tied 0 without the macro.
- `db_estado` out 4: FSM state code.

## Operation
- **Input synchronizer:** `dado_serial` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized level.
- **Tick generator:** counter 0..DIV-1; `tick` is a one-cycle pulse at DIV-1. The counter is zeroed on entry to `confirma` to phase-align to the start edge.
- **FSM (Moore):**
  - `inicial` (0x0): idle; waits for synchronized line == 0.
  - `confirma` (0x1): counts 8 ticks, then samples the line.
    - If 0: clear the bit counter and go to `espera`.
    - If 1: false start; return to `inicial`.
  - `espera` (0x3): counts 16 ticks, then goes to `recepcao`.
  - `recepcao` (0x7): one cycle. Samples the line and shifts it into bit 7 of the shift register (shift right); bit counter +1.
    - Bits 1-8 are data.
    - Bit 9 is parity (macro on).
    - The last bit is the stop bit and is not shifted.
    - If the stop bit has not yet been taken, return to `espera`; otherwise go to `final_rx`.
  - `final_rx` (0xF): one cycle.
    - Copy the shift register to `dado_recebido`.
    - Load `erro_frame` = !stop_sample and load `erro_paridade`.
    - Pulse `pronto` and set `tem_dado`.
    - Go to `inicial`.
  - Unused codes: `db_estado` = 0xE; next state `inicial`.
- The FSM returns to `inicial` at the stop-bit midpoint, so back-to-back frames are accepted without waiting out the full stop bit.
- **Erroneous frames:** data is still delivered; `pronto` and `tem_dado` are asserted and the error flags qualify the byte.
- **Error flags:** hold until the next `final_rx`; they are not cleared by `recebe`.

## Timing
- **Reset values:** `dado_recebido` = 0x00; `pronto`, `tem_dado`, `erro_frame`, `erro_paridade` = 0; `db_estado` = 0x0; FSM in `inicial`; shift register 0.
- **Reset mid-frame:** immediate abort; the partial byte is discarded and outputs take their reset values.
- **Sample points:** line falling edge to start-bit sample is 2 sync cycles + 8 ticks. Each later sample is 16 ticks after the previous one.
- **Latency:** `pronto` is high in the cycle immediately after the stop-bit `recepcao` cycle.
- **`tem_dado` set/clear:**
  - `recebe` while `tem_dado` = 1 clears it on the next edge.
  - `recebe` in the same cycle as `final_rx`: set wins, `tem_dado` = 1.
- **Overrun:** a new frame completing while `tem_dado` = 1 overwrites `dado_recebido`; `tem_dado` stays 1.
- `recebe` while `tem_dado` = 0 has no effect.

## Configuration
- **Macro `RX_SERIAL_PARIDADE_EN`.**
  - Defined: frame is 8E1 (11 bits). The parity bit is sampled after data bit 7. `erro_paridade` = (XOR of data bits) XOR parity_sample, registered at `final_rx`.
  - Undefined: frame is 8N1 (10 bits). No parity sample; `erro_paridade` is constant 0.

## Test plan
All scenarios use CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, 16 cycles/bit).
- **Single frame 0x55, valid stop:** `pronto` pulses once, 154 +/- 2 cycles after the falling edge (170 with parity). `dado_recebido` = 0x55, `tem_dado` = 1, `erro_frame` = 0.
- **Glitch:** line low for 4 cycles then high -> FSM returns to `inicial` from `confirma`; no `pronto`; `db_estado` seen as 0x1 then 0x0.
- **Framing error:** frame 0xA3 with stop bit held 0 -> `dado_recebido` = 0xA3, `erro_frame` = 1. The next clean frame 0x0F clears `erro_frame` to 0.
- **Back-to-back and overrun:** frames 0x12 then 0x34, no idle gap, no `recebe` -> two `pronto` pulses; final `dado_recebido` = 0x34; `tem_dado` = 1 throughout.
  - Pulse `recebe` -> `tem_dado` = 0 next cycle.
  - `recebe` coinciding with `final_rx` -> `tem_dado` = 1.
- **Reset mid-frame:** `reset` asserted during data bit 4 of 0xFF -> all outputs return to reset values; a following frame 0x81 is received correctly.
- **Parity (macro defined):** 0x03 with parity 0 -> `erro_paridade` = 0; 0x03 with parity 1 -> `erro_paridade` = 1.
